// File: rtl/wb_regwrite_stage_if.sv
// MEM->WB capture bus and register-file write port of the writeback stage.
// The writeback stage is the master: it drives the register-file write port.
interface wb_regwrite_stage_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          mem_valid;
    logic          mem_regwrite;
    logic          mem_memtoreg;
    logic [AW-1:0] mem_writereg;
    logic [DW-1:0] mem_aluout;
    logic [DW-1:0] mem_rdata;

    logic          RegWrite;
    logic [AW-1:0] writereg;
    logic [DW-1:0] writedate;

    modport master (
        input  mem_valid,
        input  mem_regwrite,
        input  mem_memtoreg,
        input  mem_writereg,
        input  mem_aluout,
        input  mem_rdata,
        output RegWrite,
        output writereg,
        output writedate
    );

    modport slave (
        output mem_valid,
        output mem_regwrite,
        output mem_memtoreg,
        output mem_writereg,
        output mem_aluout,
        output mem_rdata,
        input  RegWrite,
        input  writereg,
        input  writedate
    );
endinterface

// File: rtl/wb_regwrite_stage.sv
// MEM/WB pipeline register and register-file write driver with same-cycle
// bypass flags for ID and a retired-write counter.
module wb_regwrite_stage #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 flush,
    wb_regwrite_stage_if.master  bus,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    output logic                 fwd_a,
    output logic                 fwd_b,
    output logic [CNT_W-1:0]     retire_cnt
);

    logic          wb_valid;
    logic          wb_regwrite;
    logic [AW-1:0] wb_writereg;
    logic [DW-1:0] wb_data;
    logic          wb_done;
    logic          reg_write;

    // WB pipeline register; load data is selected at capture time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_writereg <= '0;
            wb_data     <= '0;
            wb_done     <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_done  <= 1'b0;
        end else if (hold) begin
            // remember that a held instruction already committed
            wb_done <= wb_done | reg_write;
        end else begin
            wb_valid    <= bus.mem_valid;
            wb_regwrite <= bus.mem_regwrite;
            wb_writereg <= bus.mem_writereg;
            wb_data     <= bus.mem_memtoreg ? bus.mem_rdata : bus.mem_aluout;
            wb_done     <= 1'b0;
        end
    end

    // register 0 is hardwired, so it is never written nor forwarded
    assign reg_write = wb_valid & wb_regwrite & (wb_writereg != '0) & ~wb_done;

    assign bus.RegWrite  = reg_write;
    assign bus.writereg  = wb_writereg;
    assign bus.writedate = wb_data;

    // register file reads are combinational, so ID must bypass this cycle's write
    assign fwd_a = reg_write & (rs == wb_writereg);
    assign fwd_b = reg_write & (rt == wb_writereg);

    // one count per committed write, wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (reg_write) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regwrite_stage.sv
// Self-checking bench for wb_regwrite_stage: directed scenarios plus a random
// run against an instruction-level model of the writeback stage.
module tb_wb_regwrite_stage;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned NREG  = 1 << AW;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             hold  = 1'b0;
    logic             flush = 1'b0;
    logic [AW-1:0]    rs    = '0;
    logic [AW-1:0]    rt    = '0;
    logic             fwd_a;
    logic             fwd_b;
    logic [CNT_W-1:0] retire_cnt;

    int tests_run = 0;
    int failures  = 0;

    wb_regwrite_stage_if #(.DW(DW), .AW(AW)) bus ();

    wb_regwrite_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .flush      (flush),
        .bus        (bus),
        .rs         (rs),
        .rt         (rt),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Environment register file fed by the DUT write port
    logic [DW-1:0] rf [NREG];
    int            commit_q[$];
    always @(posedge clk) begin
        if (rst_n && bus.RegWrite && bus.writereg != '0) begin
            rf[bus.writereg] <= bus.writedate;
            commit_q.push_back(int'(bus.writereg));
        end
    end

    // Reference model: the instruction currently in WB and whether it has committed
    bit               m_valid;
    bit               m_rw;
    bit               m_committed;
    logic [AW-1:0]    m_rd;
    logic [DW-1:0]    m_data;
    logic [CNT_W-1:0] m_cnt;
    logic [DW-1:0]    m_rf [NREG];

    function automatic bit exp_write();
        return m_valid && m_rw && (m_rd != '0) && !m_committed;
    endfunction

    task automatic set_mem(input bit v, input bit rw, input bit m2r,
                           input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                           input logic [DW-1:0] rdata);
        bus.mem_valid    = v;
        bus.mem_regwrite = rw;
        bus.mem_memtoreg = m2r;
        bus.mem_writereg = rd;
        bus.mem_aluout   = alu;
        bus.mem_rdata    = rdata;
    endtask

    // Advance the model over one edge with the current inputs, then the clock
    task automatic tick();
        bit w;
        w = exp_write();
        if (!rst_n) begin
            m_valid = 0; m_rw = 0; m_committed = 0;
            m_rd = '0; m_data = '0; m_cnt = '0;
        end else begin
            if (w) begin
                m_rf[m_rd] = m_data;
                m_cnt      = m_cnt + CNT_W'(1);
            end
            if (flush) begin
                m_valid     = 0;
                m_committed = 0;
            end else if (hold) begin
                m_committed = m_committed | w;
            end else begin
                m_valid     = bus.mem_valid;
                m_rw        = bus.mem_regwrite;
                m_rd        = bus.mem_writereg;
                m_data      = bus.mem_memtoreg ? bus.mem_rdata : bus.mem_aluout;
                m_committed = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; hold = 1; flush = 0; rs = '0; rt = '0;
        set_mem(1, 1, $urandom_range(0, 1), AW'($urandom_range(1, 31)), $urandom, $urandom);
        tick();
        tick();
        tests_run++;
        if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite: got %b expected 0", bus.RegWrite); end
        tests_run++;
        if (bus.writereg !== '0) begin failures++; $display("FAIL reset_writereg: got %0d expected 0", bus.writereg); end
        tests_run++;
        if (bus.writedate !== '0) begin failures++; $display("FAIL reset_writedate: got %h expected 0", bus.writedate); end
        tests_run++;
        if (retire_cnt !== '0) begin failures++; $display("FAIL reset_retire_cnt: got %0d expected 0", retire_cnt); end
        tests_run++;
        if ({fwd_a, fwd_b} !== 2'b00) begin failures++; $display("FAIL reset_fwd: got %b expected 00", {fwd_a, fwd_b}); end
        rst_n = 1; hold = 0;
    endtask

    task automatic test_alu_write();
        set_mem(1, 1, 0, 5'd8, 32'h0000_1234, $urandom);
        tick();
        tests_run++;
        if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL alu_regwrite: got %b expected 1", bus.RegWrite); end
        tests_run++;
        if (bus.writereg !== 5'd8) begin failures++; $display("FAIL alu_writereg: got %0d expected 8", bus.writereg); end
        tests_run++;
        if (bus.writedate !== 32'h0000_1234) begin failures++; $display("FAIL alu_writedate: got %h expected 00001234", bus.writedate); end
        set_mem(0, 0, 0, '0, '0, '0);
        tick();
        tests_run++;
        if (rf[8] !== 32'h0000_1234) begin failures++; $display("FAIL alu_rf8: got %h expected 00001234", rf[8]); end
        tests_run++;
        if (retire_cnt !== 32'd1) begin failures++; $display("FAIL alu_retire_cnt: got %0d expected 1", retire_cnt); end
    endtask

    task automatic test_load_bypass();
        set_mem(1, 1, 1, 5'd9, $urandom, 32'hDEAD_BEEF);
        rs = 5'd9; rt = 5'd3;
        tick();
        tests_run++;
        if (bus.writedate !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_writedate: got %h expected deadbeef", bus.writedate); end
        tests_run++;
        if (fwd_a !== 1'b1) begin failures++; $display("FAIL load_fwd_a: got %b expected 1", fwd_a); end
        tests_run++;
        if (fwd_b !== 1'b0) begin failures++; $display("FAIL load_fwd_b: got %b expected 0", fwd_b); end
    endtask

    task automatic test_zero_suppress();
        set_mem(1, 1, 0, 5'd0, 32'hFFFF_FFFF, $urandom);
        rs = 5'd0; rt = 5'd0;
        tick();
        tests_run++;
        if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL zero_regwrite: got %b expected 0", bus.RegWrite); end
        tests_run++;
        if (fwd_a !== 1'b0) begin failures++; $display("FAIL zero_fwd_a: got %b expected 0", fwd_a); end
        set_mem(0, 0, 0, '0, '0, '0);
        tick();
        tests_run++;
        if (retire_cnt !== 32'd2) begin failures++; $display("FAIL zero_retire_cnt: got %0d expected 2", retire_cnt); end
        tests_run++;
        if (rf[9] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zero_rf9: got %h expected deadbeef", rf[9]); end
    endtask

    task automatic test_hold();
        logic [DW-1:0] val;
        val = $urandom;
        set_mem(1, 1, 0, 5'd5, val, $urandom);
        tick();
        tests_run++;
        if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL hold_cycle1_regwrite: got %b expected 1", bus.RegWrite); end
        hold = 1;
        for (int c = 2; c <= 3; c++) begin
            set_mem(1, 1, $urandom_range(0, 1), AW'($urandom_range(1, 31)), $urandom, $urandom);
            tick();
            tests_run++;
            if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL hold_cycle%0d_regwrite: got %b expected 0", c, bus.RegWrite); end
            tests_run++;
            if (bus.writereg !== 5'd5 || bus.writedate !== val) begin
                failures++;
                $display("FAIL hold_cycle%0d_fields: got %0d/%h expected 5/%h", c, bus.writereg, bus.writedate, val);
            end
        end
        hold = 0;
        set_mem(0, 0, 0, '0, '0, '0);
        tick();
        tests_run++;
        if (retire_cnt !== 32'd3) begin failures++; $display("FAIL hold_retire_cnt: got %0d expected 3", retire_cnt); end
        tests_run++;
        if (rf[5] !== val) begin failures++; $display("FAIL hold_rf5: got %h expected %h", rf[5], val); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [1:4];
        logic [DW-1:0] alu;
        logic [DW-1:0] rd_data;
        bit            m2r;
        rst_n = 0;
        set_mem(0, 0, 0, '0, '0, '0);
        tick();
        rst_n = 1;
        flush = 1; hold = 1;
        set_mem(1, 1, 0, 5'd6, 32'hAAAA_5555, '0);
        tick();
        tests_run++;
        if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL flushhold_regwrite: got %b expected 0", bus.RegWrite); end
        flush = 0; hold = 0;
        commit_q.delete();
        for (int i = 1; i <= 4; i++) begin
            alu = $urandom; rd_data = $urandom; m2r = 1'($urandom_range(0, 1));
            exp_d[i] = m2r ? rd_data : alu;
            set_mem(1, 1, m2r, AW'(i), alu, rd_data);
            tick();
            tests_run++;
            if (bus.RegWrite !== 1'b1 || bus.writereg !== AW'(i)) begin
                failures++;
                $display("FAIL b2b_issue%0d: got we=%b reg=%0d expected we=1 reg=%0d", i, bus.RegWrite, bus.writereg, i);
            end
        end
        set_mem(0, 0, 0, '0, '0, '0);
        tick();
        tests_run++;
        if (retire_cnt !== 32'd4) begin failures++; $display("FAIL b2b_retire_cnt: got %0d expected 4", retire_cnt); end
        tests_run++;
        if (rf[6] !== 32'h0) begin failures++; $display("FAIL flushhold_rf6: got %h expected 0", rf[6]); end
        tests_run++;
        if (commit_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_commit_count: got %0d expected 4", commit_q.size());
        end else begin
            for (int i = 1; i <= 4; i++) begin
                tests_run++;
                if (commit_q[i-1] != i || rf[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL b2b_commit%0d: got reg %0d data %h expected reg %0d data %h", i, commit_q[i-1], rf[i], i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] rd;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 3) == 0);
            rd    = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
            set_mem(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), rd, $urandom, $urandom);
            rs = ($urandom_range(0, 1) == 0) ? m_rd : AW'($urandom_range(0, NREG - 1));
            rt = ($urandom_range(0, 1) == 0) ? rd   : AW'($urandom_range(0, NREG - 1));
            tick();
            tests_run++;
            if (bus.RegWrite !== exp_write()) begin
                failures++;
                $display("FAIL rand_regwrite cyc %0d: got %b expected %b", i, bus.RegWrite, exp_write());
            end
            tests_run++;
            if (fwd_a !== (exp_write() && rs == m_rd) || fwd_b !== (exp_write() && rt == m_rd)) begin
                failures++;
                $display("FAIL rand_fwd cyc %0d: got %b%b expected %b%b", i, fwd_a, fwd_b,
                         exp_write() && rs == m_rd, exp_write() && rt == m_rd);
            end
            tests_run++;
            if (retire_cnt !== m_cnt) begin
                failures++;
                $display("FAIL rand_retire_cnt cyc %0d: got %0d expected %0d", i, retire_cnt, m_cnt);
            end
            if (m_valid) begin
                tests_run++;
                if (bus.writereg !== m_rd || bus.writedate !== m_data) begin
                    failures++;
                    $display("FAIL rand_fields cyc %0d: got %0d/%h expected %0d/%h", i, bus.writereg, bus.writedate, m_rd, m_data);
                end
            end
        end
        rst_n = 1; flush = 0; hold = 0;
        set_mem(0, 0, 0, '0, '0, '0);
        tick();
        for (int r = 1; r < NREG; r++) begin
            tests_run++;
            if (rf[r] !== m_rf[r]) begin
                failures++;
                $display("FAIL rand_rf%0d: got %h expected %h", r, rf[r], m_rf[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            rf[r]   = '0;
            m_rf[r] = '0;
        end
        m_valid = 0; m_rw = 0; m_committed = 0; m_rd = '0; m_data = '0; m_cnt = '0;
        set_mem(0, 0, 0, '0, '0, '0);
        test_reset();
        test_alu_write();
        test_load_bypass();
        test_zero_suppress();
        test_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/wb_regwrite_stage.md
Name: wb_regwrite_stage

Overview:
- MEM/WB pipeline register and writeback driver: the write-side master of the 32x32 register file write port (writereg, RegWrite, writedate).
- Captures results from the MEM stage and selects the load data or the ALU result.
- Drives exactly one register-file write per retired instruction.
- Exports same-cycle bypass flags to ID, because the register file commits on the clock edge while its reads are combinational.
- Keeps a retired-write counter for debug.

Parameters:
DW, 32, data width of the write port
AW, 5, register address width (2**AW registers; register 0 hardwired to zero)
CNT_W, 32, width of the retired-write counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
hold  in  1  WB stall: keep current WB contents
flush  in  1  kill WB contents (bubble)
mem_valid  in  1  MEM stage holds a valid instruction
mem_regwrite  in  1  instruction writes a register
mem_memtoreg  in  1  1: write mem_rdata, 0: write mem_aluout
mem_writereg  in  AW  destination register
mem_aluout  in  DW  ALU result
mem_rdata  in  DW  load data
rs  in  AW  ID-stage read address A
rt  in  AW  ID-stage read address B
RegWrite  out  1  register-file write enable
writereg  out  AW  register-file write address
writedate  out  DW  register-file write data
fwd_a  out  1  ID should take writedate instead of the register-file read for rs
fwd_b  out  1  same, for rt
retire_cnt  out  CNT_W  count of committed register writes

Behaviour:
- Reset (rising clk with rst_n=0): wb_valid=0, wb_regwrite=0, wb_writereg=0, wb_data=0, wb_done=0, retire_cnt=0.
  - Resulting outputs: RegWrite=0, writereg=0, writedate=0, fwd_a=0, fwd_b=0.
  - Reset overrides hold and flush, and drops any write not yet committed.
- Per rising clk, priority order: reset > flush > hold > load.
  - flush: wb_valid<=0, wb_done<=0; address and data fields may keep their values.
  - hold: all WB fields unchanged; wb_done<=wb_done | RegWrite.
  - load: wb_valid<=mem_valid; wb_regwrite<=mem_regwrite; wb_writereg<=mem_writereg; wb_data<=mem_memtoreg ? mem_rdata : mem_aluout; wb_done<=0.
- Data selection happens at capture time; writedate is the registered value, not a mux output.
- RegWrite (combinational from registers) = wb_valid & wb_regwrite & (wb_writereg!=0) & ~wb_done.
  - Writes to register 0 are never issued.
  - While held, the write is issued only in the first cycle, so each instruction commits exactly once.
- writereg = wb_writereg; writedate = wb_data.
- Latency: a MEM-stage instruction sampled at edge N presents RegWrite during cycle N..N+1. The register file commits it at edge N+1.
- fwd_a = RegWrite & (rs==wb_writereg); fwd_b = RegWrite & (rt==wb_writereg). Both are combinational.
  - A forward of register 0 is impossible because RegWrite already excludes it.
- retire_cnt increments by 1 on every edge where RegWrite=1 and rst_n=1. It wraps modulo 2**CNT_W with no saturation.
- flush and hold both high: flush wins.
- flush while a held write is pending but uncommitted: the write is dropped.
- mem_valid=0 on load: a bubble; the data fields are still captured but are don't-care.

Test Plan:
- Reset: rst_n=0 for 2 cycles with mem_valid=1 and garbage inputs -> RegWrite=0, writereg=0, writedate=0, retire_cnt=0.
- ALU write: mem_valid=1, regwrite=1, memtoreg=0, writereg=8, aluout=0x0000_1234 -> next cycle RegWrite=1, writereg=8, writedate=0x1234. Reading reg 8 afterwards returns 0x1234; retire_cnt=1.
- Load and bypass: memtoreg=1, rdata=0xDEAD_BEEF, writereg=9 -> writedate=0xDEADBEEF. With rs=9, rt=3: fwd_a=1, fwd_b=0.
- $0 suppression: writereg=0, regwrite=1, aluout=0xFFFF_FFFF -> RegWrite=0, fwd_a=0 for rs=0, retire_cnt unchanged.
- Hold for 3 cycles on a write to reg 5:
  - Cycle 1: RegWrite=1.
  - Cycles 2-3: RegWrite=0, fields stable.
  - retire_cnt increases by exactly 1.
- Flush and hold asserted together on a pending write to reg 6 -> RegWrite=0 next cycle, reg 6 unchanged. Then a back-to-back write stream to regs 1..4 produces four commits in order with retire_cnt=4.
